// File: rtl/slow_clk_monitor.sv
// Samples a slow divided clock in the clk_in domain. It emits one-cycle rise/fall ticks and measures period and high time.
// It also flags loss of the slow clock. Optional glitch filter: define SLOW_CLK_MON_FILTER_EN.
module slow_clk_monitor #(
  parameter int CNT_W   = 28,
  parameter int TIMEOUT = 250000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  output logic             tick,
  output logic             tick_fall,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             lost
);

  typedef enum logic [1:0] {ACQUIRE, MEASURE, LOST} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             level, rise, fall;
  logic [CNT_W-1:0] cnt, cnt_nx, hcnt, hcnt_nx, period_nx, high_nx;
  logic             valid_nx, lost_nx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= level;
    end
  end

`ifdef SLOW_CLK_MON_FILTER_EN
  // The level flips only once s2 and its two previous samples agree.
  logic [1:0] hist;
  logic       level_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hist    <= 2'b00;
      level_q <= 1'b0;
    end else begin
      hist    <= {hist[0], s2};
      level_q <= level;
    end
  end

  always_comb begin
    level = level_q;
    if (s2 && (&hist))
      level = 1'b1;
    else if (!s2 && !(|hist))
      level = 1'b0;
  end
`else
  assign level = s2;
`endif

  assign rise = level & ~s3;
  assign fall = ~level & s3;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= ACQUIRE;
      tick         <= 1'b0;
      tick_fall    <= 1'b0;
      cnt          <= '0;
      hcnt         <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
    end else begin
      state        <= state_nx;
      tick         <= rise;
      tick_fall    <= fall;
      cnt          <= cnt_nx;
      hcnt         <= hcnt_nx;
      period       <= period_nx;
      high_time    <= high_nx;
      period_valid <= valid_nx;
      lost         <= lost_nx;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hcnt_nx   = hcnt;
    period_nx = period;
    high_nx   = high_time;
    valid_nx  = period_valid;
    lost_nx   = lost;
    unique case (state)
      ACQUIRE: begin
        cnt_nx  = '0;
        hcnt_nx = '0;
        if (rise) begin
          state_nx = MEASURE;
          cnt_nx   = ONE;
          hcnt_nx  = ONE;
        end
      end
      MEASURE: begin
        // A rise landing on the timeout cycle still completes the measurement.
        if (rise) begin
          period_nx = cnt;
          high_nx   = hcnt;
          valid_nx  = 1'b1;
          cnt_nx    = ONE;
          hcnt_nx   = ONE;
        end else if (cnt == TIMEOUT_C) begin
          state_nx = LOST;
          lost_nx  = 1'b1;
          valid_nx = 1'b0;
        end else begin
          cnt_nx = cnt + ONE;
          if (level)
            hcnt_nx = hcnt + ONE;
        end
      end
      LOST: begin
        if (rise) begin
          state_nx = MEASURE;
          lost_nx  = 1'b0;
          cnt_nx   = ONE;
          hcnt_nx  = ONE;
        end
      end
      default: state_nx = ACQUIRE;
    endcase
  end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed self-checking bench for slow_clk_monitor. It uses one instance with TIMEOUT=50 and one with TIMEOUT=20.
// Define SLOW_CLK_MON_FILTER_EN for both bench and RTL to check the filtered build.
module tb_slow_clk_monitor;

`ifdef SLOW_CLK_MON_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        slow_clk = 1'b0;
  logic        tick, tick_fall, period_valid, lost;
  logic [27:0] period, high_time;
  logic        b_tick, b_tick_fall, b_valid, b_lost;
  logic [27:0] b_period, b_high;
  int          n_checks = 0;
  int          n_fail = 0;

  slow_clk_monitor #(.CNT_W(28), .TIMEOUT(50)) u_dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk),
    .tick(tick), .tick_fall(tick_fall), .period(period), .high_time(high_time),
    .period_valid(period_valid), .lost(lost)
  );

  slow_clk_monitor #(.CNT_W(28), .TIMEOUT(20)) u_bnd (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk),
    .tick(b_tick), .tick_fall(b_tick_fall), .period(b_period), .high_time(b_high),
    .period_valid(b_valid), .lost(b_lost)
  );

  always #5 clk_in = ~clk_in;

  // Drive one slow_clk sample, then return 1 time unit after the edge that samples it.
  task automatic step(input logic v);
    slow_clk = v;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    int ticks;
    ticks = 0;
    rst = 1'b1;
    slow_clk = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++;
    if ({tick, tick_fall, period_valid, lost} !== 4'b0000 || period !== 28'd0 || high_time !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_hold: flags=%b period=%0d high=%0d expected all 0",
               {tick, tick_fall, period_valid, lost}, period, high_time);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      if (tick || tick_fall) ticks++;
    end
    n_checks++;
    if (ticks !== 0) begin
      n_fail++;
      $display("FAIL idle_ticks: got %0d expected 0", ticks);
    end
    n_checks++;
    if ({period_valid, lost} !== 2'b00 || period !== 28'd0 || high_time !== 28'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: valid=%b lost=%b period=%0d high=%0d expected 0",
               period_valid, lost, period, high_time);
    end
  endtask

  task automatic test_steady();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) begin
        step(i < 8);
        n_checks++;
        if (tick !== (i == LAT) || tick_fall !== (i == 8 + LAT)) begin
          n_fail++;
          $display("FAIL steady_ticks p=%0d i=%0d: tick=%b fall=%b expected %b %b",
                   p, i, tick, tick_fall, (i == LAT), (i == 8 + LAT));
        end
        if (i == LAT) begin
          n_checks++;
          if (p == 0 && (period_valid !== 1'b0 || period !== 28'd0)) begin
            n_fail++;
            $display("FAIL steady_first_rise: valid=%b period=%0d expected 0 0", period_valid, period);
          end else if (p != 0 && (period_valid !== 1'b1 || period !== 28'd20 || high_time !== 28'd8)) begin
            n_fail++;
            $display("FAIL steady_measure p=%0d: valid=%b period=%0d high=%0d expected 1 20 8",
                     p, period_valid, period, high_time);
          end
        end
      end
    end
  endtask

  task automatic test_loss();
    for (int i = 0; i <= 60; i++) begin
      step(i < 8);
      if (i == LAT) begin
        n_checks++;
        if (tick !== 1'b1 || period !== 28'd20 || period_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL loss_last_rise: tick=%b period=%0d valid=%b expected 1 20 1", tick, period, period_valid);
        end
      end
      if (i == 49 + LAT) begin
        n_checks++;
        if (lost !== 1'b0 || period_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL loss_early: lost=%b valid=%b expected 0 1", lost, period_valid);
        end
      end
      if (i == 50 + LAT || i == 60) begin
        n_checks++;
        if (lost !== 1'b1 || period_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL loss_flag i=%0d: lost=%b valid=%b expected 1 0", i, lost, period_valid);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 20; i++) begin
        step(i < 8);
        if (p == 0 && i == LAT - 1) begin
          n_checks++;
          if (lost !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_hold: lost=%b expected 1", lost);
          end
        end
        if (p == 0 && i == LAT) begin
          n_checks++;
          if (tick !== 1'b1 || lost !== 1'b0 || period_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_tick: tick=%b lost=%b valid=%b expected 1 0 0", tick, lost, period_valid);
          end
        end
        if (p == 1 && i == LAT) begin
          n_checks++;
          if (period_valid !== 1'b1 || period !== 28'd20 || high_time !== 28'd8) begin
            n_fail++;
            $display("FAIL restart_measure: valid=%b period=%0d high=%0d expected 1 20 8",
                     period_valid, period, high_time);
          end
        end
      end
    end
  endtask

  task automatic test_boundary();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        step(i < 8);
        n_checks++;
        if (b_lost !== 1'b0 || b_tick_fall !== (i == 8 + LAT)) begin
          n_fail++;
          $display("FAIL boundary_lost p=%0d i=%0d: lost=%b fall=%b expected 0 %b",
                   p, i, b_lost, b_tick_fall, (i == 8 + LAT));
        end
        if (i == LAT) begin
          n_checks++;
          if (b_tick !== 1'b1 || b_period !== 28'd20 || b_high !== 28'd8 || b_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_period p=%0d: tick=%b period=%0d high=%0d valid=%b expected 1 20 8 1",
                     p, b_tick, b_period, b_high, b_valid);
          end
        end
      end
    end
  endtask

  // Divider toggle value 4: period 10, high time 5.
  task automatic test_divider();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 10; i++) begin
        step(i < 5);
        if (i == LAT) begin
          n_checks++;
          if (p == 0 && (period !== 28'd20 || high_time !== 28'd8)) begin
            n_fail++;
            $display("FAIL divider_switch: period=%0d high=%0d expected 20 8", period, high_time);
          end else if (p != 0 && (period !== 28'd10 || high_time !== 28'd5 || period_valid !== 1'b1)) begin
            n_fail++;
            $display("FAIL divider_measure p=%0d: period=%0d high=%0d valid=%b expected 10 5 1",
                     p, period, high_time, period_valid);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        if (p == 0 && i == LAT + 5) begin
          rst = 1'b1;
          #1;
          n_checks++;
          if ({tick, tick_fall, period_valid, lost} !== 4'b0000 || period !== 28'd0 || high_time !== 28'd0) begin
            n_fail++;
            $display("FAIL mid_reset: flags=%b period=%0d high=%0d expected all 0",
                     {tick, tick_fall, period_valid, lost}, period, high_time);
          end
        end
        if (p == 0 && i == LAT + 7) rst = 1'b0;
        step(i < 4);
        if (p == 1 && i == LAT) begin
          n_checks++;
          if (tick !== 1'b1 || period !== 28'd0 || period_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_acquire: tick=%b period=%0d valid=%b expected 1 0 0", tick, period, period_valid);
          end
        end
        if (p == 2 && i == LAT) begin
          n_checks++;
          if (period !== 28'd20 || high_time !== 28'd4 || period_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_measure: period=%0d high=%0d valid=%b expected 20 4 1",
                     period, high_time, period_valid);
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    int ticks, first;
    int exp_glitch;
    `ifdef SLOW_CLK_MON_FILTER_EN
    exp_glitch = 0;
    `else
    exp_glitch = 1;
    `endif
    for (int w = 2; w <= 3; w++) begin
      ticks = 0;
      first = -1;
      for (int i = 0; i < 14; i++) begin
        step(i < w);
        if (tick) begin
          ticks++;
          if (first < 0) first = i;
        end
      end
      n_checks++;
      if (w == 2 && (ticks !== exp_glitch || (exp_glitch == 1 && first !== LAT))) begin
        n_fail++;
        $display("FAIL glitch_2cyc: ticks=%0d at=%0d expected %0d at %0d", ticks, first, exp_glitch, LAT);
      end else if (w == 3 && (ticks !== 1 || first !== LAT)) begin
        n_fail++;
        $display("FAIL pulse_3cyc: ticks=%0d at=%0d expected 1 at %0d", ticks, first, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_loss();
    test_boundary();
    test_divider();
    test_reset_mid();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slow_clk_monitor.md
# slow_clk_monitor

Receive-side companion to the team's clock divider: samples a slow divided clock (nominally 1 Hz-class) in the fast clk_in domain, synchronizes it, and produces single-cycle tick enables plus a measured period and high time. It also flags loss of the slow clock. It sits between any divided-clock source and the fast-domain logic (debouncer, score FSM) so that fast logic uses clk_in-domain enables instead of clocking on a derived clock.

## Interface
- CNT_W, 28: width of period/high-time counters and outputs.
- TIMEOUT, 250000000: clk_in cycles without a rising edge before lost is raised; must be ≥ 2 and < 2^CNT_W.

- clk_in  input  1  fast system clock (40 MHz), all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- slow_clk  input  1  divided clock under observation; asynchronous to clk_in.
- tick  output  1  one-cycle pulse per detected slow_clk rising edge.
- tick_fall  output  1  one-cycle pulse per detected slow_clk falling edge.
- period  output  CNT_W  clk_in cycles between the last two detected rising edges.
- high_time  output  CNT_W  clk_in cycles slow_clk was high in the last complete period.
- period_valid  output  1  period/high_time hold a complete measurement.
- lost  output  1  no rising edge for TIMEOUT cycles.

## Operation
- Synchronizer: 2 flops (s1, s2) then history flop s3; all reset to 0. rise = s2 & ~s3, fall = ~s2 & s3.
- tick, tick_fall: registered from rise/fall.
- State machine, reset state ACQUIRE:
  - ACQUIRE: cnt = 0, hcnt = 0. On rise → MEASURE, cnt ← 1, hcnt ← 1.
  - MEASURE: cnt += 1 each cycle; hcnt += 1 while s2 = 1. On rise: period ← cnt, high_time ← hcnt, period_valid ← 1, cnt ← 1, hcnt ← 1. If cnt == TIMEOUT with no rise this cycle → LOST, lost ← 1, period_valid ← 0.
  - LOST: counters held. On rise → MEASURE, lost ← 0, cnt ← 1, hcnt ← 1. period_valid stays 0 until the next complete period.
- rise and TIMEOUT in the same cycle: rise wins; the measurement is stored and no transition to LOST occurs.
- The first rise after ACQUIRE or LOST only starts a measurement; it never updates period.
- Counters cannot overflow: cnt ≤ TIMEOUT < 2^CNT_W, and hcnt ≤ cnt.
- A divider with toggle value T yields period = 2·(T+1) and high_time = T+1.

## Timing
- Reset values: tick = 0, tick_fall = 0, period = 0, high_time = 0, period_valid = 0, lost = 0, state = ACQUIRE.
- Latency: slow_clk first sampled high at posedge k → tick high during the cycle after posedge k+2, for exactly 1 cycle. tick_fall has the same latency.
- period, high_time, and period_valid update on the same posedge that raises tick.
- lost rises on the posedge where cnt reaches TIMEOUT. It clears on the posedge that raises the next tick.
- Asserting rst mid-measurement forces all outputs to reset values immediately. After release, the first rise is treated as an acquisition edge.

## Configuration
- SLOW_CLK_MON_FILTER_EN defined: a 3-sample glitch filter sits after s2. The filtered level changes only after 3 consecutive identical s2 samples. This adds 2 cycles to tick and tick_fall latency (tick high after posedge k+4). Pulses or gaps shorter than 3 clk_in cycles are ignored. Edge detection, hcnt, and the FSM use the filtered level.
- Not defined: no filter; s2 feeds edge detection directly, with the latency given under Timing.

## Test plan
- Reset/idle: rst high then low, slow_clk held 0 for 100 cycles → all outputs 0, state ACQUIRE, no tick.
- Steady clock: slow_clk period 20 cycles with 8 high → one tick per 20 cycles. After the second rise: period = 20, high_time = 8, period_valid = 1. tick appears 3 cycles after the first sampled-high posedge.
- Loss: TIMEOUT = 50, slow_clk stops low after valid periods → lost = 1 and period_valid = 0 exactly 50 cycles after the last rise. On restart, lost clears with the first tick, and period_valid returns after the next rise.
- Boundary: TIMEOUT = 20, slow_clk period exactly 20 → the rise coincides with TIMEOUT, lost stays 0, and period = 20 repeatedly.
- Reset mid-measurement: rst pulsed 5 cycles after a rise → outputs reset at once. The next rise gives no period update; the following rise gives period = 20.
- Filter (SLOW_CLK_MON_FILTER_EN): 2-cycle high glitch → no tick. 3-cycle high pulse → tick at posedge k+4. Without the macro, the 2-cycle glitch produces a tick.
